// File: rtl/delta_dram_responder_pkg.sv
// Shared definitions for the DRAM responder: word width, FSM state encoding
// and the byte-address to word-index mapping.
package delta_dram_responder_pkg;

  localparam int DRAM_WORD_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_RESP = 3'd4
  } resp_state_e;

  // Word index of a byte address; kept 32 bits wide so that indices beyond
  // the array remain visible to the out-of-range check.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/delta_dram_responder_if.sv
// DRAM request/response handshake between the accelerator controller
// (master) and the memory-side responder (slave).
interface delta_dram_responder_if;

  logic        DRAM_Read;
  logic        DRAM_Write;
  logic [31:0] DRAM_Address;
  logic [31:0] DRAM_WriteData;
  logic [31:0] DRAM_ReadData;
  logic        DRAM_DataReady;
  logic        DRAM_WriteDone;

  modport master (
    output DRAM_Read, DRAM_Write, DRAM_Address, DRAM_WriteData,
    input  DRAM_ReadData, DRAM_DataReady, DRAM_WriteDone
  );

  modport slave (
    input  DRAM_Read, DRAM_Write, DRAM_Address, DRAM_WriteData,
    output DRAM_ReadData, DRAM_DataReady, DRAM_WriteDone
  );

endinterface

// File: rtl/delta_dram_responder_array.sv
// Backing word array: one write port, one combinational read port for the
// responder FSM and one registered read port for the backdoor.
module delta_dram_array
  import delta_dram_responder_pkg::*;
#(
  parameter int MEM_WORDS = 65536
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          we,
  input  logic [$clog2(MEM_WORDS)-1:0]  waddr,
  input  logic [DRAM_WORD_BITS-1:0]     wdata,
  input  logic [$clog2(MEM_WORDS)-1:0]  raddr,
  output logic [DRAM_WORD_BITS-1:0]     rdata,
  input  logic                          bd_ren,
  input  logic [$clog2(MEM_WORDS)-1:0]  bd_raddr,
  output logic [DRAM_WORD_BITS-1:0]     bd_rdata
);

  logic [DRAM_WORD_BITS-1:0] mem [MEM_WORDS];
  logic [DRAM_WORD_BITS-1:0] bd_rdata_d, bd_rdata_q;

  // Array contents survive reset; only the write port updates them.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  // Backdoor read data holds until the next backdoor read.
  always_comb begin
    bd_rdata_d = bd_rdata_q;
    if (bd_ren) bd_rdata_d = mem[bd_raddr];
  end

  // Registered backdoor read output, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) bd_rdata_q <= '0;
    else       bd_rdata_q <= bd_rdata_d;
  end

  assign bd_rdata = bd_rdata_q;

endmodule

// File: rtl/delta_dram_responder.sv
// Memory-side end of the DRAM request interface: answers Read/Write level
// requests after a fixed latency with a one-cycle completion pulse, and
// exposes a backdoor port for preload and readback.
module delta_dram_responder
  import delta_dram_responder_pkg::*;
#(
  parameter int MEM_WORDS     = 65536,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  delta_dram_responder_if.slave         dram,
  input  logic                          bd_en,
  input  logic                          bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  bd_addr,
  input  logic [DRAM_WORD_BITS-1:0]     bd_wdata,
  output logic [DRAM_WORD_BITS-1:0]     bd_rdata,
  output logic                          busy,
  output logic                          err_oob,
  output logic                          err_conflict,
  output logic [31:0]                   rd_count,
  output logic [31:0]                   wr_count,
  output logic [31:0]                   abort_count
);

  localparam int          AW      = $clog2(MEM_WORDS);
  localparam logic [31:0] RD_LOAD = 32'(READ_LATENCY - 1);
  localparam logic [31:0] WR_LOAD = 32'(WRITE_LATENCY - 1);

  resp_state_e state_d, state_q;
  logic [31:0] lat_cnt_d, lat_cnt_q;
  logic [31:0] idx_d, idx_q;
  logic [DRAM_WORD_BITS-1:0] wdata_d, wdata_q;
  logic [DRAM_WORD_BITS-1:0] rdata_d, rdata_q;
  logic        ready_d, ready_q;
  logic        done_d, done_q;
  logic        err_oob_d, err_oob_q;
  logic        err_conflict_d, err_conflict_q;
  logic [31:0] rd_count_d, rd_count_q;
  logic [31:0] wr_count_d, wr_count_q;
  logic [31:0] abort_count_d, abort_count_q;

  logic                      oob;
  logic                      arr_we;
  logic [AW-1:0]             arr_waddr;
  logic [DRAM_WORD_BITS-1:0] arr_wdata;
  logic [DRAM_WORD_BITS-1:0] arr_rdata;

  assign oob = (idx_q >= 32'(MEM_WORDS));

  delta_dram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clock    (clock),
    .reset    (reset),
    .we       (arr_we),
    .waddr    (arr_waddr),
    .wdata    (arr_wdata),
    .raddr    (idx_q[AW-1:0]),
    .rdata    (arr_rdata),
    .bd_ren   (bd_en & ~bd_we),
    .bd_raddr (bd_addr),
    .bd_rdata (bd_rdata)
  );

  // Write-port mux: the WR_RESP commit and backdoor writes are exclusive
  // because backdoor writes are only accepted in IDLE.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = idx_q[AW-1:0];
    arr_wdata = wdata_q;
    if (state_q == ST_WR_RESP) begin
      arr_we = ~oob;
    end else if ((state_q == ST_IDLE) && bd_en && bd_we) begin
      arr_we    = 1'b1;
      arr_waddr = bd_addr;
      arr_wdata = bd_wdata;
    end
  end

  // Next-state, latency countdown, completion pulses, counters and errors.
  always_comb begin
    state_d        = state_q;
    lat_cnt_d      = lat_cnt_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    ready_d        = 1'b0;
    done_d         = 1'b0;
    err_oob_d      = err_oob_q;
    err_conflict_d = err_conflict_q;
    rd_count_d     = rd_count_q;
    wr_count_d     = wr_count_q;
    abort_count_d  = abort_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dram.DRAM_Write) begin
          idx_d     = word_index(dram.DRAM_Address);
          wdata_d   = dram.DRAM_WriteData;
          lat_cnt_d = WR_LOAD;
          state_d   = (WRITE_LATENCY == 1) ? ST_WR_RESP : ST_WR_WAIT;
          if (dram.DRAM_Read) err_conflict_d = 1'b1;
        end else if (dram.DRAM_Read) begin
          idx_d     = word_index(dram.DRAM_Address);
          lat_cnt_d = RD_LOAD;
          state_d   = (READ_LATENCY == 1) ? ST_RD_RESP : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!dram.DRAM_Read) begin
          state_d       = ST_IDLE;
          abort_count_d = abort_count_q + 32'd1;
        end else begin
          lat_cnt_d = lat_cnt_q - 32'd1;
          if (lat_cnt_q == 32'd1) state_d = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        ready_d    = 1'b1;
        rdata_d    = oob ? '0 : arr_rdata;
        rd_count_d = rd_count_q + 32'd1;
        if (oob) err_oob_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_WR_WAIT: begin
        if (!dram.DRAM_Write) begin
          state_d       = ST_IDLE;
          abort_count_d = abort_count_q + 32'd1;
        end else begin
          lat_cnt_d = lat_cnt_q - 32'd1;
          if (lat_cnt_q == 32'd1) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        done_d     = 1'b1;
        wr_count_d = wr_count_q + 32'd1;
        if (oob) err_oob_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      lat_cnt_q      <= '0;
      rdata_q        <= '0;
      ready_q        <= 1'b0;
      done_q         <= 1'b0;
      err_oob_q      <= 1'b0;
      err_conflict_q <= 1'b0;
      rd_count_q     <= '0;
      wr_count_q     <= '0;
      abort_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      lat_cnt_q      <= lat_cnt_d;
      rdata_q        <= rdata_d;
      ready_q        <= ready_d;
      done_q         <= done_d;
      err_oob_q      <= err_oob_d;
      err_conflict_q <= err_conflict_d;
      rd_count_q     <= rd_count_d;
      wr_count_q     <= wr_count_d;
      abort_count_q  <= abort_count_d;
    end
  end

  // Latched request address and write data; meaningful only while busy.
  always_ff @(posedge clock) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  assign dram.DRAM_ReadData  = rdata_q;
  assign dram.DRAM_DataReady = ready_q;
  assign dram.DRAM_WriteDone = done_q;
  assign busy                = (state_q != ST_IDLE);
  assign err_oob             = err_oob_q;
  assign err_conflict        = err_conflict_q;
  assign rd_count            = rd_count_q;
  assign wr_count            = wr_count_q;
  assign abort_count         = abort_count_q;

endmodule

// File: tb/tb_delta_dram_responder.sv
// Directed bench for delta_dram_responder with default parameters
// (65536 words, read latency 4, write latency 2).
module tb_delta_dram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        bd_en, bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_wdata, bd_rdata;
  logic        busy, err_oob, err_conflict;
  logic [31:0] rd_count, wr_count, abort_count;

  int n_tests = 0;
  int n_fail  = 0;

  delta_dram_responder_if dif();

  delta_dram_responder #(
    .MEM_WORDS(65536), .READ_LATENCY(4), .WRITE_LATENCY(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dram        (dif),
    .bd_en       (bd_en),
    .bd_we       (bd_we),
    .bd_addr     (bd_addr),
    .bd_wdata    (bd_wdata),
    .bd_rdata    (bd_rdata),
    .busy        (busy),
    .err_oob     (err_oob),
    .err_conflict(err_conflict),
    .rd_count    (rd_count),
    .wr_count    (wr_count),
    .abort_count (abort_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [8];
  int          lat, other, k, cnt;
  int          pulse_cyc [3];
  logic [31:0] got [3];
  logic [31:0] exp_b2b [3];
  logic [31:0] rdv, bdv;
  int          exp_rd, exp_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bd_wr(input int idx, input logic [31:0] d);
    @(negedge clock);
    bd_en = 1'b1; bd_we = 1'b1; bd_addr = 16'(idx); bd_wdata = d;
    @(negedge clock);
    bd_en = 1'b0; bd_we = 1'b0;
  endtask

  task automatic bd_rd(input int idx, output logic [31:0] d);
    @(negedge clock);
    bd_en = 1'b1; bd_we = 1'b0; bd_addr = 16'(idx);
    @(posedge clock); #1;
    d = bd_rdata;
    @(negedge clock);
    bd_en = 1'b0;
  endtask

  // Raise the request(s) at a negedge, count edges from the sampling edge
  // until the expected pulse, then drop the request inside the pulse cycle.
  task automatic xact(input bit wr, input bit rd, input logic [31:0] addr,
                      input logic [31:0] wd, output int l,
                      output logic [31:0] d, output int oth);
    @(negedge clock);
    dif.DRAM_Write = wr; dif.DRAM_Read = rd;
    dif.DRAM_Address = addr; dif.DRAM_WriteData = wd;
    l = -1; oth = 0; d = 32'h0;
    for (int n = 0; n < 20 && l < 0; n++) begin
      @(posedge clock); #1;
      if (wr ? dif.DRAM_WriteDone : dif.DRAM_DataReady) begin
        l = n; d = dif.DRAM_ReadData;
      end
      if (wr ? dif.DRAM_DataReady : dif.DRAM_WriteDone) oth++;
    end
    @(negedge clock);
    dif.DRAM_Read = 1'b0; dif.DRAM_Write = 1'b0;
  endtask

  // Count pulses of either kind over a quiet window.
  task automatic quiet(input int cycles, output int c);
    c = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clock); #1;
      if (dif.DRAM_DataReady || dif.DRAM_WriteDone) c++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 4};
    vecs[1] = '{1'b1, 32'h0000_0080, 32'h1234_5678, 32'h1234_5678, 2};
    vecs[2] = '{1'b0, 32'h0000_0080, 32'h0,         32'h1234_5678, 4};
    vecs[3] = '{1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'h0,         32'hA5A5_A5A5, 4};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 4};
    vecs[6] = '{1'b1, 32'h0003_FFFC, 32'hCAFE_F00D, 32'hCAFE_F00D, 2};
    vecs[7] = '{1'b0, 32'h0003_FFFC, 32'h0,         32'hCAFE_F00D, 4};
    exp_b2b[0] = 32'h1111_1111;
    exp_b2b[1] = 32'h2222_2222;
    exp_b2b[2] = 32'h3333_3333;

    reset = 1'b1; bd_en = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    dif.DRAM_Read = 1'b0; dif.DRAM_Write = 1'b0;
    dif.DRAM_Address = '0; dif.DRAM_WriteData = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ready",    32'(dif.DRAM_DataReady), 32'h0);
    check("reset_done",     32'(dif.DRAM_WriteDone), 32'h0);
    check("reset_rdata",    dif.DRAM_ReadData, 32'h0);
    check("reset_busy",     32'(busy), 32'h0);
    check("reset_err",      {30'h0, err_oob, err_conflict}, 32'h0);
    check("reset_counts",   rd_count | wr_count | abort_count, 32'h0);
    check("reset_bd_rdata", bd_rdata, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    bd_wr(16'h10, 32'hDEAD_BEEF);
    bd_wr(0, 32'h1111_1111);
    bd_wr(1, 32'h2222_2222);
    bd_wr(2, 32'h3333_3333);
    bd_wr(5, 32'h0000_0005);

    exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < 8; i++) begin
      xact(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdv, other);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_other_pulse", i), 32'(other), 32'h0);
      quiet(1, cnt);
      check($sformatf("vec%0d_pulse_width", i), 32'(cnt), 32'h0);
      if (vecs[i].wr) begin
        exp_wr++;
        bd_rd(int'(vecs[i].addr >> 2), bdv);
        check($sformatf("vec%0d_array", i), bdv, vecs[i].exp_data);
      end else begin
        exp_rd++;
        check($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_data);
      end
      check($sformatf("vec%0d_rd_count", i), rd_count, 32'(exp_rd));
      check($sformatf("vec%0d_wr_count", i), wr_count, 32'(exp_wr));
    end

    // Read held high across three completions, address stepped per pulse.
    @(negedge clock);
    dif.DRAM_Read = 1'b1; dif.DRAM_Address = 32'h0;
    k = 0;
    for (int n = 0; n < 60 && k < 3; n++) begin
      @(posedge clock); #1;
      if (dif.DRAM_DataReady) begin
        pulse_cyc[k] = n; got[k] = dif.DRAM_ReadData; k++;
        @(negedge clock);
        if (k < 3) dif.DRAM_Address = 32'(4 * k);
        else dif.DRAM_Read = 1'b0;
      end
    end
    @(negedge clock);
    dif.DRAM_Read = 1'b0;
    check("b2b_pulses", 32'(k), 32'd3);
    check("b2b_first_lat", 32'(pulse_cyc[0]), 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i < k) check($sformatf("b2b_data%0d", i), got[i], exp_b2b[i]);
      if (i > 0 && i < k)
        check($sformatf("b2b_spacing%0d", i), 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd5);
    end
    exp_rd += 3;
    check("b2b_rd_count", rd_count, 32'(exp_rd));

    // Read and Write together: write wins.
    xact(1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, lat, rdv, other);
    exp_wr++;
    check("conflict_latency", 32'(lat), 32'd2);
    check("conflict_no_ready", 32'(other), 32'h0);
    quiet(6, cnt);
    check("conflict_quiet", 32'(cnt), 32'h0);
    check("conflict_err", 32'(err_conflict), 32'h1);
    bd_rd(16'h40, bdv);
    check("conflict_array", bdv, 32'h0BAD_F00D);
    check("conflict_counts", {rd_count[15:0], wr_count[15:0]}, {16'(exp_rd), 16'(exp_wr)});

    // Abort: Read dropped during the second wait cycle.
    @(negedge clock);
    dif.DRAM_Read = 1'b1; dif.DRAM_Address = 32'h40;
    @(posedge clock); #1;
    check("abort_busy_wait", 32'(busy), 32'h1);
    @(posedge clock);
    @(negedge clock);
    dif.DRAM_Read = 1'b0;
    @(posedge clock); #1;
    check("abort_busy_idle", 32'(busy), 32'h0);
    check("abort_count", abort_count, 32'h1);
    quiet(8, cnt);
    check("abort_no_pulse", 32'(cnt), 32'h0);
    check("abort_rd_count", rd_count, 32'(exp_rd));

    // Backdoor write while busy must be dropped.
    @(negedge clock);
    dif.DRAM_Read = 1'b1; dif.DRAM_Address = 32'h40;
    @(posedge clock);
    @(negedge clock);
    bd_en = 1'b1; bd_we = 1'b1; bd_addr = 16'h5; bd_wdata = 32'h0000_0099;
    @(negedge clock);
    bd_en = 1'b0; bd_we = 1'b0;
    lat = -1;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(posedge clock); #1;
      if (dif.DRAM_DataReady) begin lat = n; rdv = dif.DRAM_ReadData; end
    end
    @(negedge clock);
    dif.DRAM_Read = 1'b0;
    exp_rd++;
    check("busybd_ready_seen", 32'(lat >= 0), 32'h1);
    check("busybd_rdata", rdv, 32'hDEAD_BEEF);
    bd_rd(5, bdv);
    check("busybd_dropped", bdv, 32'h0000_0005);

    // Out-of-range read and write.
    xact(1'b0, 1'b1, 32'h0004_0000, 32'h0, lat, rdv, other);
    exp_rd++;
    check("oob_rd_latency", 32'(lat), 32'd4);
    check("oob_rd_data", rdv, 32'h0);
    check("oob_err", 32'(err_oob), 32'h1);
    xact(1'b1, 1'b0, 32'h0004_0000, 32'hFFFF_FFFF, lat, rdv, other);
    exp_wr++;
    check("oob_wr_latency", 32'(lat), 32'd2);
    bd_rd(0, bdv);
    check("oob_wr_discarded", bdv, 32'h1111_1111);
    check("oob_counts", {rd_count[15:0], wr_count[15:0]}, {16'(exp_rd), 16'(exp_wr)});

    // Reset in RD_WAIT drops the read and clears control state only.
    @(negedge clock);
    dif.DRAM_Read = 1'b1; dif.DRAM_Address = 32'h40;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1; dif.DRAM_Read = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_outputs", {dif.DRAM_ReadData[29:0], dif.DRAM_DataReady, dif.DRAM_WriteDone}, 32'h0);
    check("rst_mid_errs", {30'h0, err_oob, err_conflict}, 32'h0);
    check("rst_mid_counts", rd_count | wr_count | abort_count, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    quiet(8, cnt);
    check("rst_mid_no_pulse", 32'(cnt), 32'h0);
    bd_rd(16'h10, bdv);
    check("rst_mid_array_intact", bdv, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
